// File: rtl/reflex_ctrl_pkg.sv
// Shared constants for the reflex-measurement controller: state encoding,
// LFSR seed/taps and default timing limits.
package reflex_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EARLY = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_MIN_DELAY_MS = 1000;
    localparam int DEF_MAX_MS       = 9999;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reflex_ctrl_ms_prescaler.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and flags the terminal count,
// so the first tick arrives CLK_PER_MS cycles after a restart.
module ms_prescaler #(
    parameter int CLK_PER_MS = 100000
) (
    input  logic ck,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == CW'(CLK_PER_MS - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CW'(CLK_PER_MS - 1));

endmodule

// File: rtl/reflex_ctrl.sv
// Reflex-test controller: random wait, stimulus LED, and per-millisecond
// clear/enable pulses for the downstream BCD counter.
module reflex_ctrl
    import reflex_ctrl_pkg::*;
#(
    parameter int CLK_PER_MS   = 100000,
    parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
    parameter int MAX_MS       = DEF_MAX_MS
) (
    input  logic ck,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_stop,
    output logic cnt_clear,
    output logic cnt_enable,
    output logic led,
    output logic early,
    output logic timeout,
    output logic busy
);

    localparam int DELAY_W = $clog2(MIN_DELAY_MS + 2048);

    state_e               state_q, state_d;
    logic [15:0]          lfsr_q;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [13:0]          elapsed_q, elapsed_d;
    logic                 clear_q, clear_d;
    logic                 enable_q, enable_d;
    logic                 led_q, led_d;
    logic                 early_q, early_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 restart;
    logic                 tick;

    ms_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_prescaler (
        .ck     (ck),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        elapsed_d = elapsed_q;
        clear_d   = 1'b0;
        enable_d  = 1'b0;
        led_d     = led_q;
        early_d   = early_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        restart   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HOLD, ST_EARLY: begin
                if (btn_start) begin
                    state_d   = ST_WAIT;
                    delay_d   = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[10:0]);
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                    clear_d   = 1'b1;
                    busy_d    = 1'b1;
                    led_d     = 1'b0;
                    restart   = 1'b1;
                end
            end
            ST_WAIT: begin
                // A stop landing on the expiry tick still counts as early.
                if (btn_stop) begin
                    state_d = ST_EARLY;
                    early_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (delay_q <= DELAY_W'(1)) begin
                        state_d   = ST_RUN;
                        led_d     = 1'b1;
                        elapsed_d = '0;
                        restart   = 1'b1;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (btn_stop) begin
                    state_d = ST_HOLD;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    enable_d  = 1'b1;
                    elapsed_d = elapsed_q + 14'd1;
                    if (elapsed_q + 14'd1 == 14'(MAX_MS)) begin
                        state_d   = ST_HOLD;
                        timeout_d = 1'b1;
                        led_d     = 1'b0;
                        busy_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            led_q     <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_next(lfsr_q);
            clear_q   <= clear_d;
            enable_q  <= enable_d;
            led_q     <= led_d;
            early_q   <= early_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Delay and elapsed are always loaded before use, so they carry no reset.
    always_ff @(posedge ck) begin
        delay_q   <= delay_d;
        elapsed_q <= elapsed_d;
    end

    assign cnt_clear  = clear_q;
    assign cnt_enable = enable_q;
    assign led        = led_q;
    assign early      = early_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule

// File: doc/reflex_ctrl.md
# reflex_ctrl

Control FSM for the reflex-measurement design, directly upstream of the 4-digit BCD millisecond counter. It waits a pseudo-random delay after a start press, lights the stimulus LED, and drives that counter's `clear` and `enable` inputs with one pulse per elapsed millisecond until the stop press arrives. It also flags early presses and a 9999 ms timeout. Button inputs arrive already debounced and synchronised as single-cycle pulses.

## Interface
- CLK_PER_MS, 100000: clock cycles per millisecond (≥2).
- MIN_DELAY_MS, 1000: minimum random wait, in ms.
- MAX_MS, 9999: RUN length in ms that forces timeout; keeps the BCD display from wrapping.

- ck  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- btn_start  in  1  start pulse, one cycle wide.
- btn_stop  in  1  stop/reaction pulse, one cycle wide.
- cnt_clear  out  1  one-cycle pulse to the counter `clear`.
- cnt_enable  out  1  one-cycle pulse per elapsed ms, to the counter `enable`.
- led  out  1  stimulus LED; high only in RUN.
- early  out  1  stop pressed during WAIT; held until the next start.
- timeout  out  1  MAX_MS reached without a stop; held until the next start.
- busy  out  1  high in WAIT and RUN.

## Operation
- States: IDLE, WAIT, RUN, HOLD, EARLY. Reset enters IDLE.
- IDLE, HOLD, EARLY:
  - btn_start → WAIT.
  - Load delay_ms = MIN_DELAY_MS + lfsr[10:0], giving 1000..3047 ms.
  - Clear early and timeout. Pulse cnt_clear. Restart the prescaler at 0.
  - btn_stop is ignored.
- WAIT:
  - Each ms tick decrements delay_ms.
  - btn_stop → EARLY, early=1.
  - On the tick where delay_ms reaches 0 → RUN. led=1, elapsed=0, prescaler restarted.
  - btn_start is ignored.
- RUN:
  - Each tick pulses cnt_enable and increments elapsed (14 bits).
  - btn_stop → HOLD, led=0.
  - If elapsed reaches MAX_MS after a tick → HOLD, timeout=1, led=0.
  - btn_start is ignored.
- HOLD: counter value is frozen; cnt_enable=0.
- Prescaler: counts 0..CLK_PER_MS-1. The tick fires on the terminal count, so the first tick comes CLK_PER_MS cycles after restart.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1 on reset. Advances every clock regardless of state.
- Simultaneous events:
  - Stop and tick in RUN: stop wins; no cnt_enable pulse that cycle.
  - Stop and expiry in WAIT: early wins.
  - Start and stop in IDLE/HOLD/EARLY: start wins.
- Reset mid-operation: state becomes IDLE at that edge; all outputs 0; no cnt_clear pulse.

## Timing
- All outputs are registered and go to 0 on reset.
- Start sampled at edge n: cnt_clear high and busy high during cycle n+1 only.
- Stop sampled at edge n in RUN: led low and busy low from cycle n+1.
- The cnt_enable pulse is registered, one cycle after the internal tick.
- The counter value after a round equals the number of cnt_enable pulses, which is at most MAX_MS.
- Reaction time = pulse count in ms, with resolution 1 ms. Error ≤1 ms, biased low, because the prescaler is aligned to LED rise.

## Structure
- Shared constants file:
  - state encoding (3-bit localparams);
  - LFSR seed and tap positions;
  - default MIN_DELAY_MS and MAX_MS.
- Sub-module `ms_prescaler`:
  - ports: ck, reset, restart, tick;
  - parameter CLK_PER_MS;
  - counter width $clog2(CLK_PER_MS).
- LFSR, delay/elapsed counters and the FSM live in reflex_ctrl.

## Test plan
(Use CLK_PER_MS=4, MIN_DELAY_MS=3, MAX_MS=20 for the bench.)
- Reset held 3 cycles → all outputs 0; start, stop and reset released together → still IDLE, no pulses.
- Start after reset → cnt_clear high exactly 1 cycle.
  - led rises (3 + lfsr[10:0] sampled at the start edge) × 4 cycles later.
  - Stop after 7 ticks → exactly 7 cnt_enable pulses; led=0, busy=0 next cycle.
- Stop during WAIT → early=1, led never rises, zero cnt_enable pulses. Next start clears early.
- No stop in RUN → exactly 20 cnt_enable pulses, then timeout=1, led=0, state HOLD.
- Stop on the same cycle as a tick in RUN → that pulse is suppressed (count N-1). Start during RUN → ignored.
- Reset asserted mid-RUN → led, busy and cnt_enable are 0 after that edge; the next start begins a fresh round with a cnt_clear pulse.
